// File: rtl/subword_mem_ctrl_pkg.sv
// Shared definitions for the sub-word memory controller: access-type
// encodings, FSM state type and the store lane-merge helper.
package subword_mem_ctrl_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  // Access whose address is not a multiple of its width.
  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    if (op == OP_LW || op == OP_SW) m = (lo != 2'b00);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) m = lo[0];
    return m;
  endfunction

  // Insert the right-justified store data into the addressed lane of the
  // previously read word; SW replaces the whole word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lo);
    logic [31:0] r;
    r = word;
    case (op)
      OP_SW: r = wd;
      OP_SH: r = lo[1] ? {wd[15:0], word[15:0]} : {word[31:16], wd[15:0]};
      OP_SB: begin
        case (lo)
          2'd0: r = {word[31:8], wd[7:0]};
          2'd1: r = {word[31:16], wd[7:0], word[7:0]};
          2'd2: r = {word[31:24], wd[7:0], word[15:0]};
          default: r = {wd[7:0], word[23:0]};
        endcase
      end
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/subword_mem_ctrl_load_align.sv
// load_align: picks the addressed half/byte lane out of a memory word and
// sign- or zero-extends it according to the load type.
//   word : captured memory word
//   op   : access type (package encoding)
//   lo   : byte offset Addr[1:0]
//   data : extended load result (0 for store encodings)
module load_align
  import subword_mem_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  op,
  input  logic [1:0]  lo,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = lo[1] ? word[31:16] : word[15:0];
    case (lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  always_comb begin
    data = 32'd0;
    case (op)
      OP_LW:  data = word;
      OP_LH:  data = {{16{half[15]}}, half};
      OP_LHU: data = {16'd0, half};
      OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU: data = {24'd0, byte_sel};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/subword_mem_ctrl.sv
// subword_mem_ctrl: MEM-stage controller turning byte/half/word loads and
// stores into single-word memory accesses. Sub-word stores are done as
// read-modify-write. Optional macro UNALIGNED_TRAP_EN makes misaligned
// accesses complete immediately with MisalignErr instead of touching memory.
// Ports:
//   Clk, Rst (async, active low)
//   Req/Op/Addr/WrData    : request from the pipeline, held until Ack
//   Ack/RdData/MisalignErr: one-cycle completion with load result / fault
//   Busy                  : stall while the FSM is not idle
//   MemAddr/MemRdEn/MemWrEn/MemWrData/MemRdData : word memory, 1-cycle read
module subword_mem_ctrl
  import subword_mem_ctrl_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic [2:0]        Op,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WrData,
  output logic              Ack,
  output logic [31:0]       RdData,
  output logic              Busy,
  output logic              MisalignErr,
  output logic [MEM_AW-1:0] MemAddr,
  output logic              MemRdEn,
  output logic              MemWrEn,
  output logic [31:0]       MemWrData,
  input  logic [31:0]       MemRdData
);

  state_t             state, next;
  logic [2:0]         op_q;
  logic [MEM_AW+1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        word_q;
  logic [31:0]        ld_data;
  logic               trap_now;
  logic               err_q;

  // Address bits above the memory window do not select anything.
  logic unused_addr;
  assign unused_addr = ^Addr[31:MEM_AW+2];

`ifdef UNALIGNED_TRAP_EN
  assign trap_now = misaligned(Op, Addr[1:0]);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                       err_q <= 1'b0;
    else if (state == IDLE && Req)  err_q <= trap_now;
  end
`else
  // Unused low address bits are simply ignored by lane selection.
  assign trap_now = 1'b0;
  assign err_q    = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      state <= next;
      if (state == IDLE && Req) begin
        op_q    <= Op;
        addr_q  <= Addr[MEM_AW+1:0];
        wdata_q <= WrData;
      end
      if (state == CAP) word_q <= MemRdData;
    end
  end

  load_align u_load_align (
    .word (word_q),
    .op   (op_q),
    .lo   (addr_q[1:0]),
    .data (ld_data)
  );

  always_comb begin
    next      = state;
    Ack       = 1'b0;
    Busy      = 1'b1;
    MemRdEn   = 1'b0;
    MemWrEn   = 1'b0;
    MemWrData = 32'd0;
    RdData    = 32'd0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Req) begin
          if (trap_now)         next = DONE;
          else if (Op == OP_SW) next = WR;   // full word: no read needed
          else                  next = RD;
        end
      end
      RD: begin
        MemRdEn = 1'b1;
        next    = CAP;
      end
      CAP: next = is_store(op_q) ? WR : DONE;
      WR: begin
        MemWrEn   = 1'b1;
        MemWrData = store_merge(word_q, wdata_q, op_q, addr_q[1:0]);
        next      = DONE;
      end
      DONE: begin
        Ack = 1'b1;
        if (!is_store(op_q) && !err_q) RdData = ld_data;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign MisalignErr = Ack & err_q;
  assign MemAddr     = addr_q[MEM_AW+1:2];

endmodule

// File: tb/tb_subword_mem_ctrl.sv
// Randomised scoreboard bench for subword_mem_ctrl: a word memory model
// serves the DUT, an arithmetic reference model predicts load results,
// write data and completion cycles, and a monitor checks them on Ack/MemWrEn.
module tb_subword_mem_ctrl;

  localparam int MEM_AW = 10;
  localparam int DEPTH  = 1 << MEM_AW;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic              Clk, Rst, Req;
  logic [2:0]        Op;
  logic [31:0]       Addr, WrData;
  logic              Ack, Busy, MisalignErr, MemRdEn, MemWrEn;
  logic [31:0]       RdData, MemWrData, MemRdData;
  logic [MEM_AW-1:0] MemAddr;

  subword_mem_ctrl #(.MEM_AW(MEM_AW)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Op(Op), .Addr(Addr), .WrData(WrData),
    .Ack(Ack), .RdData(RdData), .Busy(Busy), .MisalignErr(MisalignErr),
    .MemAddr(MemAddr), .MemRdEn(MemRdEn), .MemWrEn(MemWrEn),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge Clk) begin
    if (MemRdEn) MemRdData <= mem[MemAddr];
    if (MemWrEn) mem[MemAddr] <= MemWrData;
  end

  typedef struct { logic [31:0] rd; logic err; int cyc; } exp_t;
  typedef struct { logic [MEM_AW-1:0] idx; logic [31:0] data; } wexp_t;
  exp_t  eq[$];
  wexp_t wq[$];
  exp_t  e_mon;
  wexp_t w_mon;

  int checks = 0, errors = 0, rd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge Clk) begin
    if (Rst) begin
      if (MemRdEn) rd_cnt++;
      if (MemWrEn) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h data %h", MemAddr, MemWrData);
        end else begin
          w_mon = wq.pop_front();
          check("wr_addr", 32'(MemAddr), 32'(w_mon.idx));
          check("wr_data", MemWrData, w_mon.data);
        end
      end
      if (Ack) begin
        if (eq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: rd %h", RdData);
        end else begin
          e_mon = eq.pop_front();
          check("rd_data", RdData, e_mon.rd);
          check("misalign", 32'(MisalignErr), 32'(e_mon.err));
          check("ack_cycle", cyc, e_mon.cyc);
        end
      end else begin
        check("rd_zero_no_ack", RdData, 32'd0);
      end
    end
  end

  function automatic bit model_trap(input logic [2:0] op, input logic [31:0] a);
`ifdef UNALIGNED_TRAP_EN
    if ((op == LW || op == SW) && a[1:0] != 2'b00) return 1'b1;
    if ((op == LH || op == LHU || op == SH) && a[0]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Issue one request (called at a negedge with the DUT idle); the expected
  // outcome is computed from plain lane arithmetic and queued.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input bit early_drop);
    int          idx, lat, hsh, bsh;
    bit          trap, got;
    logic [31:0] word, rd, nw, mask;
    idx  = int'(a[MEM_AW+1:2]);
    trap = model_trap(op, a);
    word = ref_mem[idx];
    hsh  = a[1] ? 16 : 0;
    bsh  = 8 * int'(a[1:0]);
    rd   = 32'd0;
    nw   = word;
    if (trap) lat = 1;
    else if (op == SW) lat = 2;
    else if (op == SH || op == SB) lat = 4;
    else lat = 3;
    if (!trap) begin
      case (op)
        LW:  rd = word;
        LH:  begin rd = (word >> hsh) & 32'hFFFF; if (rd[15]) rd = rd | 32'hFFFF_0000; end
        LHU: rd = (word >> hsh) & 32'hFFFF;
        LB:  begin rd = (word >> bsh) & 32'hFF; if (rd[7]) rd = rd | 32'hFFFF_FF00; end
        LBU: rd = (word >> bsh) & 32'hFF;
        SW:  nw = wd;
        SH:  begin mask = 32'hFFFF << hsh; nw = (word & ~mask) | ((wd & 32'hFFFF) << hsh); end
        default: begin mask = 32'hFF << bsh; nw = (word & ~mask) | ((wd & 32'hFF) << bsh); end
      endcase
      if (op == SW || op == SH || op == SB) begin
        wq.push_back('{idx: idx[MEM_AW-1:0], data: nw});
        ref_mem[idx] = nw;
      end
    end
    eq.push_back('{rd: rd, err: trap, cyc: cyc + lat});
    Req = 1'b1; Op = op; Addr = a; WrData = wd;
    @(posedge Clk);
    if (early_drop) begin #1; Req = 1'b0; end
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (Ack) begin got = 1'b1; break; end
    end
    Req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ack_timeout: op %0d addr %h got no Ack within 12 cycles", op, a);
    end
    @(negedge Clk);
  endtask

  logic [31:0] saved;
  int          r0;

  initial begin
    Rst = 1'b0; Req = 1'b0; Op = 3'd0; Addr = 32'd0; WrData = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h8001_7F02; ref_mem[4] = 32'h8001_7F02;
    #1;
    check("reset_ack", 32'(Ack), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_strobes", {30'd0, MemRdEn, MemWrEn}, 32'd0);
    check("reset_wrdata", MemWrData, 32'd0);
    check("reset_memaddr", 32'(MemAddr), 32'd0);
    check("reset_rd_err", RdData | 32'(MisalignErr), 32'd0);
    repeat (3) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    // Directed cases on mem[4] = 8001_7F02
    do_op(LH,  32'h12, 32'd0, 1'b0);
    do_op(LBU, 32'h10, 32'd0, 1'b0);
    do_op(LB,  32'h11, 32'd0, 1'b1);
    do_op(SB,  32'h13, 32'h0000_00AB, 1'b0);
    check("sb_mem", mem[4], 32'hAB01_7F02);
    r0 = rd_cnt;
    do_op(SW,  32'h20, 32'hDEAD_BEEF, 1'b0);
    check("sw_no_read", rd_cnt, r0);
    check("sw_mem", mem[8], 32'hDEAD_BEEF);
    r0 = rd_cnt;
    do_op(LW,  32'h22, 32'd0, 1'b0);
`ifdef UNALIGNED_TRAP_EN
    check("trap_no_read", rd_cnt, r0);
`else
    check("lw_unaligned_read", rd_cnt, r0 + 1);
`endif

    // Randomised traffic, including Req dropped early
    for (int n = 0; n < 150; n++)
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3) == 0);

    // Reset while an SH sits in WR: the write must be cancelled
    saved = ref_mem[16];
    Req = 1'b1; Op = SH; Addr = 32'h40; WrData = 32'h1234;
    @(posedge Clk); #1 Req = 1'b0;
    @(posedge Clk);
    @(posedge Clk); #2;
    check("sh_in_wr", 32'(MemWrEn), 32'd1);
    Rst = 1'b0;
    #1;
    check("rst_wren", 32'(MemWrEn), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_memaddr", 32'(MemAddr), 32'd0);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("rst_mem_unchanged", mem[16], saved);
    do_op(LW, 32'h40, 32'd0, 1'b0);

    check("exp_queue_empty", eq.size(), 32'd0);
    check("wr_queue_empty", wq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/subword_mem_ctrl.md
SUBWORD_MEM_CTRL -- requirements
Module: subword_mem_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 10: the data-memory word-address width.
REQ-002 The block SHALL have port Clk, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port Req, input, 1 bit: memory-access request from the MEM stage, held until Ack.
REQ-005 The block SHALL have port Op, input, 3 bits: access type, using the package encoding.
REQ-006 The block SHALL have port Addr, input, 32 bits: byte address.
REQ-007 The block SHALL have port WrData, input, 32 bits: store data, right-justified.
REQ-008 The block SHALL have port Ack, output, 1 bit: one-cycle completion pulse.
REQ-009 The block SHALL have port RdData, output, 32 bits: extended load result, valid while Ack=1.
REQ-010 The block SHALL have port Busy, output, 1 bit: high in every non-IDLE state (pipeline stall).
REQ-011 The block SHALL have port MisalignErr, output, 1 bit: alignment fault, valid while Ack=1.
REQ-012 The block SHALL have port MemAddr, output, MEM_AW bits: word address, equal to Addr[MEM_AW+1:2].
REQ-013 The block SHALL have ports MemRdEn and MemWrEn, outputs, 1 bit each: memory strobes.
REQ-014 The block SHALL have port MemWrData, output, 32 bits: full word written to memory.
REQ-015 The block SHALL have port MemRdData, input, 32 bits: memory read word, valid the cycle after MemRdEn.

Function
REQ-016 The FSM SHALL have the states IDLE, RD, CAP, WR and DONE.
REQ-017 In IDLE with Req=1, the block SHALL register Op, Addr and WrData (accept edge); the registered copies are used thereafter.
REQ-018 State sequence after the accept edge SHALL be:
  - LW/LH/LHU/LB/LBU: RD, CAP, DONE.
  - SW: WR, DONE.
  - SH/SB: RD, CAP, WR, DONE.
REQ-019 MemRdEn SHALL be 1 only in RD, and MemWrEn SHALL be 1 only in WR.
REQ-020 CAP SHALL latch MemRdData into an internal word register.
REQ-021 Ack SHALL be 1 only in DONE, and DONE SHALL always go to IDLE.
REQ-022 Back-to-back requests SHALL be accepted at the earliest on the edge after DONE (IDLE cycle).
REQ-023 Half select SHALL be: Addr[1]=0 selects bits 15:0; Addr[1]=1 selects bits 31:16.
REQ-024 Byte select SHALL be: Addr[1:0]=k selects bits 8k+7:8k.
REQ-025 Load extension SHALL be: LH/LB sign-extend to 32 bits; LHU/LBU zero-extend; LW passes the word unchanged.
REQ-026 SH/SB SHALL merge WrData[15:0]/WrData[7:0] into the selected lane of the captured word, other lanes unchanged; SW SHALL write WrData unchanged.
REQ-027 RdData SHALL be 0 outside DONE and for stores.
REQ-028 If Req drops before Ack (protocol violation), the operation SHALL still complete normally.

Reset
REQ-029 Rst=0 SHALL force, immediately and asynchronously, FSM=IDLE and all outputs and internal registers to 0, including mid-operation.
REQ-030 A reset during WR SHALL drop MemWrEn in the same cycle, and no further write SHALL be issued.

Configuration
REQ-031 With macro UNALIGNED_TRAP_EN defined, a misaligned access (LW/SW with Addr[1:0]!=0, or LH/LHU/SH with Addr[0]=1) SHALL go IDLE->DONE with no memory strobes, Ack=1, MisalignErr=1 and RdData=0.
REQ-032 Without UNALIGNED_TRAP_EN, low address bits unused by the access width SHALL be ignored and MisalignErr SHALL be tied to 0.

Structure
REQ-033 A shared package SHALL hold the Op encodings (OP_LW=0, OP_LH=1, OP_LHU=2, OP_LB=3, OP_LBU=4, OP_SW=5, OP_SH=6, OP_SB=7) and the FSM state typedef.
REQ-034 Lane extraction and extension SHALL live in one combinational sub-module, load_align, instantiated once.

Verification
REQ-035 The bench SHALL cover: mem[4]=0x8001_7F02; LH Addr=0x12 -> Ack on the 3rd edge after accept, RdData=0xFFFF_8001.
REQ-036 The bench SHALL cover: same word; LBU Addr=0x10 -> RdData=0x0000_0002; LB Addr=0x11 -> 0x0000_007F.
REQ-037 The bench SHALL cover: SB Addr=0x13, WrData=0xAB -> exactly one MemWrEn, MemWrData=0xAB01_7F02, Ack on the 4th edge.
REQ-038 The bench SHALL cover: SW Addr=0x20, WrData=0xDEAD_BEEF -> no MemRdEn, MemWrEn on the 1st edge, Ack on the 2nd.
REQ-039 The bench SHALL cover: Rst=0 asserted in WR of an SH -> MemWrEn=0 immediately, FSM=IDLE, memory unchanged.
REQ-040 The bench SHALL cover: with UNALIGNED_TRAP_EN, LW Addr=0x22 -> Ack on the 1st edge, MisalignErr=1, no strobes.
